path_util: RTL and testbench

Byte-stream path joiner. Accepts three ASCII strings in order (base file path, relative path, suffix) and emits the directory of the base file joined with the relative path and the suffix, one byte per cycle. Sits beside the ROM/memory loaders in the simulation utility area, resolving data-file paths relative to the source file that references them.

---
 rtl/path_util_pkg.sv | 17 +
 rtl/path_util_buf.sv | 33 +++
 rtl/path_util.sv | 150 +++++++++++++++
 tb/tb_path_util.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/path_util_pkg.sv
// path_util_pkg: shared FSM states, ASCII constants and field indices for path_util.
package path_util_pkg;
  typedef enum logic [2:0] {
    LOAD_BASE,
    LOAD_REL,
    LOAD_SUF,
    EMIT_DIR,
    EMIT_REL,
    EMIT_SUF,
    EMIT_EMPTY
  } state_t;
  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] DOT = 8'h2E;
  localparam int BASE = 0;
  localparam int REL = 1;
  localparam int SUF = 2;
endpackage

// File: rtl/path_util_buf.sv
// path_util_buf: MAX_LEN-byte field store with append pointer, sticky overflow and async read.
module path_util_buf
  import path_util_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter int AW = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [7:0]       din,
  input  logic [AW-1:0]    addr,
  output logic [LEN_W-1:0] len,
  output logic             ovf,
  output logic [7:0]       dout
);
  localparam logic [LEN_W-1:0] CAP = LEN_W'(MAX_LEN);
  logic [7:0] mem [MAX_LEN];
  logic full;
  assign full = len == CAP;
  assign dout = mem[addr];
  always_ff @(posedge clk)
    if (wr && !full) mem[len[AW-1:0]] <= din;
  // Bytes past capacity are dropped; only the flag records them.
  always_ff @(posedge clk)
    if (rst || clr) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (wr && full) ovf <= 1'b1;
    else if (wr) len <= len + 1'b1;
endmodule

// File: rtl/path_util.sv
// path_util: joins dirname(base) + rel + suffix as a byte stream; PATH_UTIL_DOT_STRIP_EN drops a leading "./" from rel.
module path_util
  import path_util_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_keep,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_keep,
  output logic       out_last,
  output logic       busy,
  output logic       err
);
  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] CAP = LEN_W'(MAX_LEN);
  state_t state, nxt;
  logic live, in_hs, out_hs, clr, has_slash, abs_rel, dot, dir_ne, rel_ne, suf_ne, at_end;
  logic [LEN_W-1:0] ptr, nptr, slash_idx, dir_n, rs, seg_end;
  logic [LEN_W-1:0] len [3];
  logic [7:0] rd [3];
  logic [7:0] r0;
  logic [2:0] wr, ovf;

  assign in_ready = live && (state inside {LOAD_BASE, LOAD_REL, LOAD_SUF});
  assign out_valid = state inside {EMIT_DIR, EMIT_REL, EMIT_SUF, EMIT_EMPTY};
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign clr = out_hs && out_last;
  assign wr = {3{in_hs && in_keep}} & {state == LOAD_SUF, state == LOAD_REL, state == LOAD_BASE};

  for (genvar i = 0; i < 3; i++) begin : g_buf
    path_util_buf #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .AW(AW)) u_buf (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .wr(wr[i]),
      .din(in_data),
      .addr(ptr[AW-1:0]),
      .len(len[i]),
      .ovf(ovf[i]),
      .dout(rd[i])
    );
  end

  // Directory end and rel prefix are captured while loading so emit never needs a second read port.
  always_ff @(posedge clk)
    if (rst || clr) begin
      has_slash <= 1'b0;
      slash_idx <= '0;
      r0 <= '0;
    end else begin
      if (wr[BASE] && in_data == SLASH && len[BASE] != CAP) begin
        has_slash <= 1'b1;
        slash_idx <= len[BASE];
      end
      if (wr[REL] && len[REL] == '0) r0 <= in_data;
    end

`ifdef PATH_UTIL_DOT_STRIP_EN
  logic [7:0] r1;
  always_ff @(posedge clk)
    if (rst || clr) r1 <= '0;
    else if (wr[REL] && len[REL] == LEN_W'(1)) r1 <= in_data;
  assign dot = len[REL] >= LEN_W'(2) && r0 == DOT && r1 == SLASH;
`else
  assign dot = 1'b0;
`endif

  assign abs_rel = len[REL] != '0 && r0 == SLASH;
  assign rs = dot ? LEN_W'(2) : '0;
  assign dir_n = abs_rel || !has_slash ? '0 : slash_idx + 1'b1;
  assign dir_ne = dir_n != '0;
  assign rel_ne = len[REL] > rs;
  assign suf_ne = len[SUF] != '0 || (state == LOAD_SUF && in_keep);
  assign seg_end = state == EMIT_DIR ? dir_n : state == EMIT_REL ? len[REL] : len[SUF];
  assign at_end = ptr + 1'b1 == seg_end;

  assign out_keep = out_valid && state != EMIT_EMPTY;
  assign out_data = !out_keep ? '0 : state == EMIT_DIR ? rd[BASE] : state == EMIT_REL ? rd[REL] : rd[SUF];
  assign out_last = state == EMIT_EMPTY || at_end && (state == EMIT_SUF ||
                    (state == EMIT_REL && !suf_ne) || (state == EMIT_DIR && !rel_ne && !suf_ne));

  always_ff @(posedge clk)
    if (rst) begin
      state <= LOAD_BASE;
      ptr <= '0;
      live <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      ptr <= nptr;
      live <= 1'b1;
      busy <= in_hs ? 1'b1 : clr ? 1'b0 : busy;
      err <= in_hs && !busy ? 1'b0 : err | (|ovf);
    end

  // Each transition lands on the next non-empty segment so empty ones cost no cycle.
  always_comb begin
    nxt = state;
    nptr = ptr;
    case (state)
      LOAD_BASE: if (in_hs && in_last) nxt = LOAD_REL;
      LOAD_REL:  if (in_hs && in_last) nxt = LOAD_SUF;
      LOAD_SUF:
        if (in_hs && in_last) begin
          nxt = dir_ne ? EMIT_DIR : rel_ne ? EMIT_REL : suf_ne ? EMIT_SUF : EMIT_EMPTY;
          nptr = !dir_ne && rel_ne ? rs : '0;
        end
      EMIT_DIR:
        if (out_hs) begin
          nptr = ptr + 1'b1;
          if (at_end) begin
            nxt = rel_ne ? EMIT_REL : suf_ne ? EMIT_SUF : LOAD_BASE;
            nptr = rel_ne ? rs : '0;
          end
        end
      EMIT_REL:
        if (out_hs) begin
          nptr = ptr + 1'b1;
          if (at_end) begin
            nxt = suf_ne ? EMIT_SUF : LOAD_BASE;
            nptr = '0;
          end
        end
      EMIT_SUF:
        if (out_hs) begin
          nptr = ptr + 1'b1;
          if (at_end) begin
            nxt = LOAD_BASE;
            nptr = '0;
          end
        end
      EMIT_EMPTY: if (out_hs) nxt = LOAD_BASE;
      default: begin
        nxt = LOAD_BASE;
        nptr = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_path_util.sv
// tb_path_util: randomized and directed checks of path_util against a string-level path model.
module tb_path_util;
  localparam int ML = 16;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_keep = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, out_keep, out_last, busy, err;
  logic [7:0] out_data;

  int vec = 0, bad = 0;
  bit first_chk = 0;
  bq_t base_q, rel_q, suf_q, exp_q;
  logic [7:0] cs [6] = '{8'h61, 8'h2F, 8'h2E, 8'h78, 8'h2F, 8'h62};

  path_util #(.MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic build_exp(output bit e);
    bq_t b, r, s;
    int ls;
    b = base_q; r = rel_q; s = suf_q; ls = -1;
    e = b.size() > ML || r.size() > ML || s.size() > ML;
    while (b.size() > ML) void'(b.pop_back());
    while (r.size() > ML) void'(r.pop_back());
    while (s.size() > ML) void'(s.pop_back());
    for (int i = 0; i < b.size(); i++) if (b[i] == 8'h2F) ls = i;
    exp_q = {};
    if (!(r.size() > 0 && r[0] == 8'h2F)) for (int i = 0; i <= ls; i++) exp_q.push_back(b[i]);
`ifdef PATH_UTIL_DOT_STRIP_EN
    if (r.size() >= 2 && r[0] == 8'h2E && r[1] == 8'h2F) begin
      void'(r.pop_front());
      void'(r.pop_front());
    end
`endif
    foreach (r[i]) exp_q.push_back(r[i]);
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic put(input logic [7:0] d, input logic k, input logic l);
    int t;
    if ($urandom_range(3) == 0) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vec++; bad++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
    if (first_chk) begin
      first_chk = 0;
      vec++;
      if ({busy, err} !== 2'b10) begin
        bad++;
        $display("FAIL job_start busy,err got %b want 10", {busy, err});
      end
    end
  endtask

  task automatic send(input bq_t q);
    if (q.size() == 0) put(8'h00, 1'b0, 1'b1);
    else if ($urandom_range(1) == 0) foreach (q[i]) put(q[i], 1'b1, i == q.size() - 1);
    else begin
      foreach (q[i]) put(q[i], 1'b1, 1'b0);
      put(8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic set_fields(input string b, input string r, input string s);
    base_q = {}; rel_q = {}; suf_q = {};
    for (int i = 0; i < b.len(); i++) base_q.push_back(b[i]);
    for (int i = 0; i < r.len(); i++) rel_q.push_back(r[i]);
    for (int i = 0; i < s.len(); i++) suf_q.push_back(s[i]);
  endtask

  task automatic rand_field(output bq_t q, input bit dotted);
    int n;
    q = {};
    n = $urandom_range(ML + 2);
    if (dotted) begin
      q.push_back(8'h2E);
      q.push_back(8'h2F);
    end
    for (int i = 0; i < n; i++) q.push_back(cs[$urandom_range(5)]);
  endtask

  task automatic run_job(input int mode);
    bit e, done, stall;
    int n, nexp;
    logic [9:0] want;
    logic [10:0] held;
    build_exp(e);
    nexp = exp_q.size() == 0 ? 1 : exp_q.size();
    first_chk = 1;
    send(base_q); send(rel_q); send(suf_q);
    vec++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid got %b want 1", out_valid);
    end
    n = 0; done = 0; stall = 0; held = '0;
    for (int c = 0; c < 4000 && !done; c++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1)) : (c % 4 == 0 || c % 4 == 3);
      #1;
      vec++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL emit_in_ready got %b want 0", in_ready);
      end
      if (stall) begin
        vec++;
        if ({out_valid, out_keep, out_last, out_data} !== held) begin
          bad++;
          $display("FAIL hold got %h want %h", {out_valid, out_keep, out_last, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        want = exp_q.size() == 0 ? 10'h100 : n < exp_q.size() ? {1'b1, n == exp_q.size() - 1, exp_q[n]} : 10'h000;
        vec++;
        if ({out_keep, out_last, out_data} !== want || n >= nexp) begin
          bad++;
          $display("FAIL beat%0d keep,last,data got %h want %h", n, {out_keep, out_last, out_data}, want);
        end
        n++;
        done = out_last;
      end
      stall = out_valid && !out_ready;
      held = {out_valid, out_keep, out_last, out_data};
      @(negedge clk);
    end
    out_ready = 1'b0;
    vec++;
    if (!done || n != nexp) begin
      bad++;
      $display("FAIL beat_count got %0d (done=%0d) want %0d", n, done, nexp);
    end
    vec++;
    if ({in_ready, busy, out_valid, err} !== {1'b1, 1'b0, 1'b0, e}) begin
      bad++;
      $display("FAIL job_end in_ready,busy,out_valid,err got %b want %b", {in_ready, busy, out_valid, err}, {3'b100, e});
    end
  endtask

  task automatic chk_idle(input string name, input logic rdy);
    vec++;
    if ({out_valid, out_data, out_keep, out_last, in_ready, busy, err} !== {12'h000, rdy, 2'b00}) begin
      bad++;
      $display("FAIL %s got %h want %h", name, {out_valid, out_data, out_keep, out_last, in_ready, busy, err},
               {12'h000, rdy, 2'b00});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset_values", 1'b0);
    rst = 1'b0;
    #1 chk_idle("first_cycle_after_reset", 1'b0);
    @(negedge clk);
    chk_idle("in_ready_rise", 1'b1);
  endtask

  task automatic test_directed();
    set_fields("a/b/c.v", "m.txt", ".hex");   run_job(0);
    set_fields("c.v", "m.txt", "");           run_job(0);
    set_fields("a/c.v", "/abs/m", "");        run_job(0);
    set_fields("", "", "");                   run_job(0);
    set_fields("a/b/memory_rom.v", "mem/mem_default.txt", ""); run_job(0);
    set_fields("/", "", ".x");                run_job(0);
  endtask

  task automatic test_dot();
    set_fields("d/f.v", "./x", "");           run_job(0);
    set_fields("d/f.v", "./", "");            run_job(0);
  endtask

  task automatic test_overflow();
    set_fields("a/b.v", "", "s");
    for (int i = 0; i < ML + 3; i++) rel_q.push_back(8'h61 + 8'(i % 20));
    run_job(0);
    set_fields("p/q", "r", "");               run_job(0);
  endtask

  task automatic test_stall();
    set_fields("dir/sub/file.v", "data.bin", ".h"); run_job(2);
    set_fields("x/y", "zz", "w");                    run_job(1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 40; j++) begin
      rand_field(base_q, 1'b0);
      rand_field(rel_q, $urandom_range(3) == 0);
      rand_field(suf_q, 1'b0);
      if ($urandom_range(2) == 0) suf_q = {};
      run_job(j % 3);
    end
  endtask

  task automatic test_mid_reset();
    set_fields("a/b/c.v", "mmmm.txt", ".hex");
    send(base_q); send(rel_q); send(suf_q);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk_idle("mid_emit_reset", 1'b0);
    rst = 1'b0;
    #1 chk_idle("mid_reset_release", 1'b0);
    @(negedge clk);
    chk_idle("mid_reset_ready", 1'b1);
    set_fields("k/l", "m", "n");              run_job(0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dot();
    test_overflow();
    test_stall();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
